wb_trace_buffer: RTL and testbench

Captures the CPU's register-writeback commit events and buffers them in a small FIFO. It drains them in order over a valid/ready port to the golden-trace comparator or debug dump logic. It sits beside the CPU top as the outbound counterpart of the bench stimulus: the bench drives clock and reset in, and this block carries architectural results out. Its counters and sticky overflow flag let a run report lost trace entries without stalling the pipeline.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_sync_fifo.sv | 67 ++++++
 rtl/wb_trace_buffer.sv | 93 +++++++++
 tb/tb_wb_trace_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared trace-entry record and field widths for the writeback trace path.
// The comparator side reuses the pack/unpack helpers.
package trace_pkg;

   localparam int unsigned TR_PC_W    = 32;
   localparam int unsigned TR_WEN_W   = 4;
   localparam int unsigned TR_WNUM_W  = 5;
   localparam int unsigned TR_DATA_W  = 32;
   localparam int unsigned TR_ENTRY_W = TR_PC_W + TR_WEN_W + TR_WNUM_W + TR_DATA_W;

   typedef struct packed {
      logic [TR_PC_W-1:0]   pc;
      logic [TR_WEN_W-1:0]  wen;
      logic [TR_WNUM_W-1:0] wnum;
      logic [TR_DATA_W-1:0] wdata;
   } trace_entry_t;

   function automatic logic [TR_ENTRY_W-1:0] trace_pack(input trace_entry_t e);
      return TR_ENTRY_W'(e);
   endfunction

   function automatic trace_entry_t trace_unpack(input logic [TR_ENTRY_W-1:0] v);
      return trace_entry_t'(v);
   endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; pointers and occupancy are reset,
// storage is not. count, full and not_empty are registered.
module trace_sync_fifo #(
   parameter  int unsigned DEPTH = 8,
   parameter  int unsigned WIDTH = 73,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [OCC_W-1:0] count,
   output logic             full,
   output logic             not_empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [OCC_W-1:0] count_nxt;

   // A push into a full FIFO is only legal when the head leaves this cycle.
   always_comb begin
      do_pop    = pop && not_empty;
      do_push   = push && (!full || do_pop);
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + OCC_W'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         full      <= 1'b0;
         not_empty <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count     <= count_nxt;
         full      <= (count_nxt == OCC_W'(DEPTH));
         not_empty <= (count_nxt != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures traceable regfile writeback commits into a FIFO drained over
// valid/ready; counts accepted and dropped events without stalling the CPU.
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned OCC_W = $clog2(DEPTH + 1),
   localparam int unsigned EVT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_valid,
   input  logic [TR_PC_W-1:0]   wb_pc,
   input  logic [TR_WEN_W-1:0]  wb_wen,
   input  logic [TR_WNUM_W-1:0] wb_wnum,
   input  logic [TR_DATA_W-1:0] wb_wdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TR_PC_W-1:0]   out_pc,
   output logic [TR_WEN_W-1:0]  out_wen,
   output logic [TR_WNUM_W-1:0] out_wnum,
   output logic [TR_DATA_W-1:0] out_wdata,
   output logic                 full,
   output logic [OCC_W-1:0]     count,
   output logic                 overflow,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic [EVT_W-1:0]     event_cnt
);

   trace_entry_t          wb_entry;
   trace_entry_t          head_entry;
   logic [TR_ENTRY_W-1:0] head_bits;
   logic                  traceable;
   logic                  pop;
   logic                  push_ok;
   logic                  drop;

   // Writes to x0 or with no byte enables carry no architectural result.
   always_comb begin
      wb_entry.pc    = wb_pc;
      wb_entry.wen   = wb_wen;
      wb_entry.wnum  = wb_wnum;
      wb_entry.wdata = wb_wdata;
      traceable      = wb_valid && (wb_wen != '0) && (wb_wnum != '0);
      pop            = out_valid && out_ready;
      push_ok        = traceable && (!full || pop);
      drop           = traceable && full && !pop;
   end

   trace_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TR_ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ok),
      .pop       (pop),
      .wdata     (trace_pack(wb_entry)),
      .rdata     (head_bits),
      .count     (count),
      .full      (full),
      .not_empty (out_valid)
   );

   always_comb begin
      head_entry = trace_unpack(head_bits);
      out_pc     = head_entry.pc;
      out_wen    = head_entry.wen;
      out_wnum   = head_entry.wnum;
      out_wdata  = head_entry.wdata;
   end

   // Loss accounting: overflow is sticky and drop_cnt saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         drop_cnt  <= '0;
         event_cnt <= '0;
      end else begin
         if (push_ok) begin
            event_cnt <= event_cnt + EVT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer against a queue-based reference model.
module tb_wb_trace_buffer;
   import trace_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [3:0]  wb_wen;
   logic [4:0]  wb_wnum;
   logic [31:0] wb_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [3:0]  out_wen;
   logic [4:0]  out_wnum;
   logic [31:0] out_wdata;
   logic        full;
   logic [OCC_W-1:0] count;
   logic        overflow;
   logic [CNT_W-1:0] drop_cnt;
   logic [31:0] event_cnt;

   wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wen(wb_wen), .wb_wnum(wb_wnum), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
      .full(full), .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .event_cnt(event_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: ordered queue of accepted entries plus loss counters.
   trace_entry_t mq[$];
   int unsigned  m_events;
   int unsigned  m_drops;
   bit           m_ovf;

   function automatic trace_entry_t rand_entry();
      trace_entry_t e;
      e.pc    = $urandom;
      e.wen   = 4'($urandom_range(1, 15));
      e.wnum  = 5'($urandom_range(1, 31));
      e.wdata = $urandom;
      return e;
   endfunction

   task automatic drive(input logic v, input trace_entry_t e);
      wb_valid = v;
      wb_pc    = e.pc;
      wb_wen   = e.wen;
      wb_wnum  = e.wnum;
      wb_wdata = e.wdata;
   endtask

   task automatic idle();
      wb_valid = 1'b0; wb_pc = '0; wb_wen = '0; wb_wnum = '0; wb_wdata = '0;
   endtask

   // Applies one clock's worth of model behaviour, then advances past the edge.
   task automatic tick();
      trace_entry_t e;
      bit tr;
      e.pc = wb_pc; e.wen = wb_wen; e.wnum = wb_wnum; e.wdata = wb_wdata;
      tr = wb_valid && (wb_wen != 4'd0) && (wb_wnum != 5'd0);
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (tr) begin
         if (mq.size() < int'(DEPTH)) begin
            mq.push_back(e);
            m_events++;
         end else begin
            m_drops++;
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      m_events = 0; m_drops = 0; m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", full); end
      n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
      n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
      n_tests++; if (event_cnt !== '0) begin n_fail++; $display("FAIL reset_event_cnt got %0d exp 0", event_cnt); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      trace_entry_t e;
      logic [TR_ENTRY_W-1:0] got;
      do_reset();
      e.pc = 32'hBFC0_0000; e.wen = 4'hF; e.wnum = 5'd2; e.wdata = 32'h1234_5678;
      drive(1'b1, e);
      tick();
      idle();
      got = {out_pc, out_wen, out_wnum, out_wdata};
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", out_valid); end
      n_tests++; if (got !== trace_pack(e)) begin n_fail++; $display("FAIL single_fields got %h exp %h", got, trace_pack(e)); end
      n_tests++; if (count !== OCC_W'(1)) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
      n_tests++; if (event_cnt !== 32'd1) begin n_fail++; $display("FAIL single_event_cnt got %0d exp 1", event_cnt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b exp 0", out_valid); end
   endtask

   task automatic test_filter();
      trace_entry_t e;
      do_reset();
      e = rand_entry(); e.wen = 4'd0;
      drive(1'b1, e); tick();
      e = rand_entry(); e.wnum = 5'd0;
      drive(1'b1, e); tick();
      e = rand_entry();
      drive(1'b0, e); tick();
      idle();
      n_tests++; if (count !== OCC_W'(mq.size())) begin n_fail++; $display("FAIL filter_count got %0d exp %0d", count, mq.size()); end
      n_tests++; if (event_cnt !== 32'(m_events)) begin n_fail++; $display("FAIL filter_event_cnt got %0d exp %0d", event_cnt, m_events); end
      n_tests++; if (drop_cnt !== CNT_W'(m_drops)) begin n_fail++; $display("FAIL filter_drop_cnt got %0d exp %0d", drop_cnt, m_drops); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL filter_valid got %0b exp 0", out_valid); end
   endtask

   task automatic fill(input int n);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, rand_entry());
         tick();
      end
      idle();
   endtask

   task automatic drain_check(input string tag);
      logic [TR_ENTRY_W-1:0] got;
      int guard;
      guard = 0;
      out_ready = 1'b1;
      while (mq.size() != 0 && guard < 4 * int'(DEPTH)) begin
         got = {out_pc, out_wen, out_wnum, out_wdata};
         n_tests++;
         if (out_valid !== 1'b1 || got !== trace_pack(mq[0])) begin
            n_fail++; $display("FAIL %s_order valid %0b got %h exp %h", tag, out_valid, got, trace_pack(mq[0]));
         end
         tick();
         guard++;
      end
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_empty got %0b exp 0", tag, out_valid); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      fill(8);
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b exp 1", full); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got %0b exp 0", overflow); end
      fill(2);
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL fill_overflow got %0b exp %0b", overflow, m_ovf); end
      n_tests++; if (drop_cnt !== CNT_W'(m_drops)) begin n_fail++; $display("FAIL fill_drop_cnt got %0d exp %0d", drop_cnt, m_drops); end
      n_tests++; if (event_cnt !== 32'(m_events)) begin n_fail++; $display("FAIL fill_event_cnt got %0d exp %0d", event_cnt, m_events); end
      n_tests++; if (count !== OCC_W'(DEPTH)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", count, DEPTH); end
      drain_check("fill");
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_sticky got %0b exp 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      fill(8);
      drive(1'b1, rand_entry());
      out_ready = 1'b1;
      tick();
      idle();
      out_ready = 1'b0;
      n_tests++; if (count !== OCC_W'(DEPTH)) begin n_fail++; $display("FAIL fpp_count got %0d exp %0d", count, DEPTH); end
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full got %0b exp 1", full); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %0b exp 0", overflow); end
      n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL fpp_drop_cnt got %0d exp 0", drop_cnt); end
      n_tests++; if (event_cnt !== 32'(m_events)) begin n_fail++; $display("FAIL fpp_event_cnt got %0d exp %0d", event_cnt, m_events); end
      drain_check("fpp");
   endtask

   task automatic test_streaming();
      logic [TR_ENTRY_W-1:0] got;
      int popped, sent, cyc;
      popped = 0; sent = 0; cyc = 0;
      do_reset();
      while (popped < 40 && cyc < 2000) begin
         if (sent < 40 && $urandom_range(0, 1) == 1) begin
            drive(1'b1, rand_entry());
            sent++;
         end else begin
            idle();
         end
         out_ready = 1'($urandom_range(0, 1));
         if (mq.size() == int'(DEPTH)) out_ready = 1'b1;
         n_tests++;
         if (count !== OCC_W'(mq.size()) || out_valid !== (mq.size() != 0)) begin
            n_fail++; $display("FAIL stream_occ count %0d valid %0b exp %0d", count, out_valid, mq.size());
         end
         if (mq.size() != 0 && out_ready) begin
            got = {out_pc, out_wen, out_wnum, out_wdata};
            n_tests++;
            if (got !== trace_pack(mq[0])) begin
               n_fail++; $display("FAIL stream_order #%0d got %h exp %h", popped, got, trace_pack(mq[0]));
            end
            popped++;
         end
         tick();
         cyc++;
      end
      idle();
      out_ready = 1'b0;
      n_tests++; if (popped != 40) begin n_fail++; $display("FAIL stream_timeout popped %0d exp 40", popped); end
      n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL stream_drop_cnt got %0d exp 0", drop_cnt); end
      n_tests++; if (event_cnt !== 32'd40) begin n_fail++; $display("FAIL stream_event_cnt got %0d exp 40", event_cnt); end
   endtask

   task automatic test_midrun_reset();
      trace_entry_t e;
      logic [TR_ENTRY_W-1:0] got;
      do_reset();
      fill(10);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      out_ready = 1'b0;
      n_tests++; if (count !== OCC_W'(5)) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 5", count); end
      #3;
      rst = 1'b1;
      #1;
      mq.delete(); m_events = 0; m_drops = 0; m_ovf = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0b exp 0", out_valid); end
      n_tests++; if (count !== '0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %0b exp 0", overflow); end
      n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL mid_drop_cnt got %0d exp 0", drop_cnt); end
      n_tests++; if (event_cnt !== '0) begin n_fail++; $display("FAIL mid_event_cnt got %0d exp 0", event_cnt); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      e = rand_entry();
      drive(1'b1, e);
      tick();
      idle();
      got = {out_pc, out_wen, out_wnum, out_wdata};
      n_tests++; if (out_valid !== 1'b1 || got !== trace_pack(e)) begin n_fail++; $display("FAIL mid_next valid %0b got %h exp %h", out_valid, got, trace_pack(e)); end
      n_tests++; if (event_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_next_event_cnt got %0d exp 1", event_cnt); end
   endtask

   initial begin
      idle();
      out_ready = 1'b0;
      rst = 1'b1;
      #2;
      test_reset();
      test_single();
      test_filter();
      test_fill_overflow();
      test_full_push_pop();
      test_streaming();
      test_midrun_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
